// File: rtl/col_enc_pkg.sv
// Shared definitions for the column run-length encoder: word tags, the
// encoder state enum and width-generic packing helpers for the three word
// formats.
package col_enc_pkg;

  // Two-bit tag carried in the top bits of every encoded word.
  localparam logic [1:0] TAG_LIT = 2'b00;
  localparam logic [1:0] TAG_RUN = 2'b01;
  localparam logic [1:0] TAG_HDR = 2'b10;
  // 2'b11 is reserved and never produced by the encoder.

  // Working width of the packing helpers. Every word, timestamp and pixel
  // is zero-extended to this width and the caller truncates the result.
  localparam int PACK_W = 64;

  typedef logic [PACK_W-1:0] pack_t;

  // Encoder sequencing: ACCEPT takes pixels and writes the first word of a
  // literal sequence; EMIT_* write the remaining words one per cycle.
  typedef enum logic [1:0] {
    ACCEPT   = 2'd0,
    EMIT_HDR = 2'd1,
    EMIT_LIT = 2'd2
  } enc_state_t;

  // All-ones mask of the low n bits.
  function automatic pack_t width_mask(input int n);
    return (pack_t'(1) << n) - pack_t'(1);
  endfunction

  // LIT = {TAG_LIT, ts[lo-1:0], pix}
  function automatic pack_t pack_lit(input int word_w, input int lo,
                                     input int pix_w, input pack_t ts,
                                     input pack_t pix);
    return (pack_t'(TAG_LIT) << (word_w - 2))
         | ((ts & width_mask(lo)) << pix_w)
         | (pix & width_mask(pix_w));
  endfunction

  // RUN = {TAG_RUN, run_len[word_w-3:0]}
  function automatic pack_t pack_run(input int word_w, input pack_t run_len);
    return (pack_t'(TAG_RUN) << (word_w - 2))
         | (run_len & width_mask(word_w - 2));
  endfunction

  // HDR = {TAG_HDR, ts[lo+word_w-3:lo]}
  function automatic pack_t pack_hdr(input int word_w, input int lo,
                                     input pack_t ts);
    return (pack_t'(TAG_HDR) << (word_w - 2))
         | ((ts >> lo) & width_mask(word_w - 2));
  endfunction

endpackage

// File: rtl/enc_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head word is presented
// combinationally on rd_data whenever the FIFO holds data, so a word
// written on one edge is visible during the following cycle.
module enc_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             empty;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign valid = !empty;
  assign level = count;

  // A pop on an empty FIFO is ignored; a push into a full FIFO is taken
  // only when the head is popped on the same edge.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Head word, forced to zero when empty so the output is clean after reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage array write port.
  // NOTE: the storage array has no reset; its contents are only observable
  // through rd_data, which is masked while the FIFO is empty, so clearing
  // the pointers and count is enough and keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
  // pointers wrap naturally.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/col_encoder_rle_ts.sv
// Column pixel encoder: folds runs of zero pixels into RUN words, emits
// nonzero pixels as LIT words carrying the low timestamp bits, and inserts
// an HDR word whenever the high timestamp window changes. Words are queued
// in an output FIFO with valid/ready handshakes on both sides.
module col_encoder_rle_ts
  import col_enc_pkg::*;
#(
  parameter int PIX_W      = 3,
  parameter int WORD_W     = 16,
  parameter int TS_W       = 32,   // must satisfy TS_W >= 2*WORD_W - 4 - PIX_W
  parameter int FIFO_DEPTH = 8     // power of two, at least 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PIX_W-1:0]              pixel_in,
  input  logic                          data_valid,
  output logic                          data_accept,
  input  logic [TS_W-1:0]               tik_tok,
  input  logic                          flush,
  output logic [WORD_W-1:0]             encoded_dat,
  output logic                          data_ready,
  input  logic                          sink_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  // Low timestamp bits carried in a LIT word.
  localparam int LO  = WORD_W - 2 - PIX_W;
  // Width of the run counter; RUN_MAX is its all-ones value.
  localparam int RUN_W = WORD_W - 2;
  localparam logic [RUN_W-1:0] RUN_MAX = '1;
  // High timestamp bits tracked to decide when a header is due.
  localparam int HI_W = TS_W - LO;

  // Registered state.
  enc_state_t        state;
  logic [RUN_W-1:0]  run;
  logic [PIX_W-1:0]  pix_q;
  logic [TS_W-1:0]   ts_q;
  logic [HI_W-1:0]   last_hi;
  logic              hdr_needed;
  logic              flush_pending;

  // Next-state and control.
  enc_state_t        state_nxt;
  logic [RUN_W-1:0]  run_nxt;
  logic [RUN_W-1:0]  run_inc;
  logic              accept_ok;
  logic              take;
  logic              latch_pix;
  logic              hdr_wr;
  logic [HI_W-1:0]   hdr_hi;
  logic              need_hdr_in;
  logic              flush_clr;

  // FIFO interface.
  logic              push;
  logic [WORD_W-1:0] push_data;
  logic              fifo_full;

  // Ready to take a pixel only in ACCEPT with room for its first word and
  // no flush waiting to be serviced. Held low while reset is asserted.
  assign accept_ok   = (state == ACCEPT) && !fifo_full && !flush_pending;
  assign data_accept = accept_ok && rst_n;
  assign take        = accept_ok && data_valid;

  assign run_inc     = run + 1'b1;
  assign need_hdr_in = hdr_needed || (tik_tok[TS_W-1:LO] != last_hi);

  // Sequencing, word selection and run counting.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    push      = 1'b0;
    push_data = '0;
    latch_pix = 1'b0;
    hdr_wr    = 1'b0;
    hdr_hi    = '0;
    flush_clr = 1'b0;

    case (state)
      ACCEPT: begin
        if (flush_pending) begin
          // Drain a pending run before any new pixel is taken.
          if (run != '0) begin
            if (!fifo_full) begin
              push      = 1'b1;
              push_data = WORD_W'(pack_run(WORD_W, pack_t'(run)));
              run_nxt   = '0;
              flush_clr = 1'b1;
            end
          end else begin
            flush_clr = 1'b1;
          end
        end else if (take) begin
          if (pixel_in == '0) begin
            // Extend the run; a saturated run is written out immediately.
            if (run_inc == RUN_MAX) begin
              push      = 1'b1;
              push_data = WORD_W'(pack_run(WORD_W, pack_t'(RUN_MAX)));
              run_nxt   = '0;
            end else begin
              run_nxt   = run_inc;
            end
          end else begin
            // Nonzero pixel: write the first word of [RUN] [HDR] LIT now.
            latch_pix = 1'b1;
            if (run != '0) begin
              push      = 1'b1;
              push_data = WORD_W'(pack_run(WORD_W, pack_t'(run)));
              run_nxt   = '0;
              state_nxt = need_hdr_in ? EMIT_HDR : EMIT_LIT;
            end else if (need_hdr_in) begin
              push      = 1'b1;
              push_data = WORD_W'(pack_hdr(WORD_W, LO, pack_t'(tik_tok)));
              hdr_wr    = 1'b1;
              hdr_hi    = tik_tok[TS_W-1:LO];
              state_nxt = EMIT_LIT;
            end else begin
              push      = 1'b1;
              push_data = WORD_W'(pack_lit(WORD_W, LO, PIX_W,
                                           pack_t'(tik_tok),
                                           pack_t'(pixel_in)));
            end
          end
        end
      end

      EMIT_HDR: begin
        if (!fifo_full) begin
          push      = 1'b1;
          push_data = WORD_W'(pack_hdr(WORD_W, LO, pack_t'(ts_q)));
          hdr_wr    = 1'b1;
          hdr_hi    = ts_q[TS_W-1:LO];
          state_nxt = EMIT_LIT;
        end
      end

      EMIT_LIT: begin
        if (!fifo_full) begin
          push      = 1'b1;
          push_data = WORD_W'(pack_lit(WORD_W, LO, PIX_W,
                                       pack_t'(ts_q), pack_t'(pix_q)));
          state_nxt = ACCEPT;
        end
      end

      default: begin
        state_nxt = ACCEPT;
      end
    endcase
  end

  // Encoder registers: state, run counter, latched pixel/timestamp, header
  // tracking and the flush request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ACCEPT;
      run           <= '0;
      pix_q         <= '0;
      ts_q          <= '0;
      last_hi       <= '0;
      hdr_needed    <= 1'b1;
      flush_pending <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= run_nxt;
      if (latch_pix) begin
        pix_q <= pixel_in;
        ts_q  <= tik_tok;
      end
      if (hdr_wr) begin
        last_hi    <= hdr_hi;
        hdr_needed <= 1'b0;
      end
      // A new flush pulse wins over clearing the previous one.
      flush_pending <= flush || (flush_pending && !flush_clr);
    end
  end

  enc_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (push_data),
    .rd_en   (sink_ready),
    .rd_data (encoded_dat),
    .valid   (data_ready),
    .full    (fifo_full),
    .level   (fifo_level)
  );

endmodule

// File: tb/tb_col_encoder_rle_ts.sv
// Directed bench for col_encoder_rle_ts: collects every popped word and
// compares it with hand-computed expected sequences.
module tb_col_encoder_rle_ts;

  localparam int PIX_W      = 3;
  localparam int WORD_W     = 16;
  localparam int TS_W       = 32;
  localparam int FIFO_DEPTH = 8;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [PIX_W-1:0]    pixel_in = '0;
  logic                data_valid = 1'b0;
  logic                data_accept;
  logic [TS_W-1:0]     tik_tok = '0;
  logic                flush = 1'b0;
  logic [WORD_W-1:0]   encoded_dat;
  logic                data_ready;
  logic                sink_ready = 1'b1;
  logic [LVL_W-1:0]    fifo_level;

  col_encoder_rle_ts #(
    .PIX_W      (PIX_W),
    .WORD_W     (WORD_W),
    .TS_W       (TS_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixel_in    (pixel_in),
    .data_valid  (data_valid),
    .data_accept (data_accept),
    .tik_tok     (tik_tok),
    .flush       (flush),
    .encoded_dat (encoded_dat),
    .data_ready  (data_ready),
    .sink_ready  (sink_ready),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [WORD_W-1:0] obs_q[$];
  int                obs_t[$];
  logic [WORD_W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record each word at the point it is handed to the sink.
  always @(negedge clk) begin
    if (rst_n && data_ready && sink_ready) begin
      obs_q.push_back(encoded_dat);
      obs_t.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] lit(input logic [TS_W-1:0] ts,
                                            input logic [PIX_W-1:0] p);
    return {2'b00, ts[10:0], p};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one pixel until it is accepted; returns just after the accept edge.
  task automatic send_pix(input string tag, input logic [PIX_W-1:0] p,
                          input logic [TS_W-1:0] ts, output int acc_cyc);
    logic got_acc;
    got_acc    = 1'b0;
    pixel_in   = p;
    tik_tok    = ts;
    data_valid = 1'b1;
    for (int i = 0; i < 100 && !got_acc; i++) begin
      @(negedge clk);
      if (data_accept) got_acc = 1'b1;
      @(posedge clk);
    end
    #1;
    data_valid = 1'b0;
    acc_cyc    = cyc;
    check({tag, "_accepted"}, 64'(got_acc), 64'd1);
  endtask

  // Stream n accepted zero pixels back to back.
  task automatic stream_zero(input string tag, input int n);
    int cnt;
    cnt        = 0;
    pixel_in   = '0;
    data_valid = 1'b1;
    for (int i = 0; i < 2 * n + 100 && cnt < n; i++) begin
      @(negedge clk);
      if (data_accept) cnt++;
      @(posedge clk);
    end
    #1;
    data_valid = 1'b0;
    check({tag, "_zero_cnt"}, 64'(cnt), 64'(n));
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  // Compare collected words with the expected sequence, then clear both.
  task automatic compare_words(input string tag);
    int n;
    check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_word%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
    obs_t.delete();
    exp_q.delete();
  endtask

  initial begin
    int a;
    int acc;

    // Reset state.
    wait_cycles(3);
    check("rst_data_ready",  64'(data_ready),  64'd0);
    check("rst_encoded_dat", 64'(encoded_dat), 64'd0);
    check("rst_fifo_level",  64'(fifo_level),  64'd0);
    check("rst_data_accept", 64'(data_accept), 64'd0);
    rst_n = 1'b1;
    wait_cycles(2);

    // 1: first pixel after reset gets a header; one word per cycle.
    send_pix("t1", 3'd5, 32'h0000_0803, a);
    wait_cycles(6);
    if (obs_t.size() == 2) begin
      check("t1_hdr_time", 64'(obs_t[0] - a), 64'd0);
      check("t1_lit_time", 64'(obs_t[1] - a), 64'd1);
    end
    exp_q = '{16'h8001, 16'h001D};
    compare_words("t1");

    // 2: pending run then a literal in the same timestamp window.
    stream_zero("t2", 20);
    send_pix("t2", 3'd3, 32'h0000_0A07, a);
    wait_cycles(6);
    exp_q = '{16'h4014, 16'h103B};
    compare_words("t2");

    // 3: saturating runs and flush of the remainder; empty flush is silent.
    stream_zero("t3", 65500);
    pulse_flush();
    wait_cycles(10);
    exp_q = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FDF};
    compare_words("t3");
    pulse_flush();
    wait_cycles(6);
    compare_words("t3_empty_flush");

    // 4: sink stalled with continuous literals; FIFO fills then drains.
    sink_ready = 1'b0;
    acc        = 0;
    data_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      pixel_in = PIX_W'((acc % 7) + 1);
      tik_tok  = 32'h800 + 32'(acc * 5);
      @(negedge clk);
      if (data_accept) begin
        exp_q.push_back(lit(tik_tok, pixel_in));
        acc++;
      end
      @(posedge clk);
      #1;
    end
    check("t4_accepted",    64'(acc),         64'(FIFO_DEPTH));
    check("t4_level_full",  64'(fifo_level),  64'(FIFO_DEPTH));
    check("t4_accept_low",  64'(data_accept), 64'd0);
    data_valid = 1'b0;
    sink_ready = 1'b1;
    wait_cycles(12);
    for (int i = 0; i + 1 < obs_t.size(); i++)
      check($sformatf("t4_drain_gap%0d", i), 64'(obs_t[i+1] - obs_t[i]), 64'd1);
    check("t4_level_empty", 64'(fifo_level), 64'd0);
    compare_words("t4");

    // 5: window change 0x7FF -> 0x800 with a run pending: RUN, HDR, LIT.
    send_pix("t5a", 3'd2, 32'h0000_07FF, a);
    stream_zero("t5", 4);
    send_pix("t5b", 3'd6, 32'h0000_0800, a);
    wait_cycles(8);
    exp_q = '{16'h8000, 16'h3FFA, 16'h4004, 16'h8001, 16'h0006};
    compare_words("t5");

    // 6: reset while in EMIT_HDR with three words queued.
    sink_ready = 1'b0;
    send_pix("t6a", 3'd1, 32'h0000_0900, a);
    send_pix("t6b", 3'd2, 32'h0000_0904, a);
    stream_zero("t6", 3);
    send_pix("t6c", 3'd4, 32'h0000_1000, a);
    check("t6_level_pre",  64'(fifo_level),  64'd3);
    check("t6_accept_pre", 64'(data_accept), 64'd0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_data_ready",  64'(data_ready),  64'd0);
    check("t6_rst_encoded_dat", 64'(encoded_dat), 64'd0);
    check("t6_rst_fifo_level",  64'(fifo_level),  64'd0);
    check("t6_rst_data_accept", 64'(data_accept), 64'd0);
    wait_cycles(2);
    rst_n      = 1'b1;
    sink_ready = 1'b1;
    wait_cycles(1);
    obs_q.delete();
    obs_t.delete();
    // Same high window as the reset value of last_hi: header still required.
    send_pix("t6d", 3'd7, 32'h0000_0007, a);
    wait_cycles(6);
    exp_q = '{16'h8000, 16'h003F};
    compare_words("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/col_encoder_rle_ts.md
Name: col_encoder_rle_ts

Overview:
- Parametrised successor to the 3-bit column encoder: compresses a per-column pixel stream into fixed-width tagged words.
- Three word types: zero-run words, timestamped literal words, and timestamp-header words.
- Adds the following, all generic in pixel, word and timestamp width and FIFO depth:
  - valid/ready backpressure on both sides
  - an output FIFO
  - run-length saturation
  - explicit flush
- Sits between the column pixel front-end and the readout serialiser.

Parameters:
- PIX_W, 3, pixel width.
- WORD_W, 16, encoded word width.
- TS_W, 32, timestamp width. Constraint: TS_W >= 2*WORD_W - 4 - PIX_W.
- FIFO_DEPTH, 8, output FIFO depth in words. Power of 2, >= 4.
- Derived: LO = WORD_W-2-PIX_W (11), RUN_MAX = 2^(WORD_W-2)-1 (16383).

Ports:
- clk  in  1  system clock, single domain.
- rst_n  in  1  asynchronous active-low reset.
- pixel_in  in  PIX_W  pixel value.
- data_valid  in  1  pixel_in valid.
- data_accept  out  1  pixel accepted this cycle when data_valid && data_accept.
- tik_tok  in  TS_W  free-running timestamp, sampled on accept.
- flush  in  1  pulse: emit any pending zero run.
- encoded_dat  out  WORD_W  FIFO head word.
- data_ready  out  1  encoded_dat valid.
- sink_ready  in  1  downstream pops the head word when data_ready && sink_ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Word formats, tag in the top 2 bits:
  - LIT = {2'b00, ts[LO-1:0], pix}
  - RUN = {2'b01, run_len[WORD_W-3:0]}
  - HDR = {2'b10, ts[LO+WORD_W-3:LO]}
  - Tag 2'b11 is reserved and never emitted.
- Reset values: all FIFO pointers 0, data_ready=0, encoded_dat=0, fifo_level=0, run=0, flush_pending=0, hdr_needed=1, state=ACCEPT, data_accept=0 during reset.
- Accept rule: data_accept = (state==ACCEPT) && !fifo_full && !flush_pending.
- At most one FIFO write per cycle.
- Zero pixel accepted: run <= run+1.
  - If run+1 == RUN_MAX, write RUN(RUN_MAX) in the same cycle and set run <= 0.
- Nonzero pixel accepted: latch pix and ts. The word sequence is [RUN(run) if run>0] [HDR if hdr_needed or ts[TS_W-1:LO] != last_hi] [LIT].
  - The first word is written in the accept cycle.
  - Remaining words are written in states EMIT_HDR then EMIT_LIT, one per cycle, stalling while the FIFO is full.
  - Return to ACCEPT in the cycle after the LIT write.
- On HDR write: last_hi <= ts[TS_W-1:LO], hdr_needed <= 0.
- RUN words carry no timestamp and never trigger HDR.
- Flush:
  - A flush pulse sets flush_pending.
  - In ACCEPT with flush_pending: if run>0, write RUN(run) when not full, then clear run and flush_pending. If run==0, clear flush_pending the next cycle with no write.
  - Flush arriving during EMIT_* is held pending until ACCEPT.
- FIFO:
  - Synchronous, first-word-fall-through.
  - A written word is visible on encoded_dat/data_ready the cycle after the write.
  - Simultaneous push and pop when full or empty are legal (level unchanged when full and popping).
  - Pop when empty is ignored.
- Latency: a nonzero pixel with no pending run and no header appears on encoded_dat 1 cycle after accept. Each extra word adds 1 cycle plus any full stalls.
- No word is ever dropped; ordering is preserved.
- Reset mid-operation clears pending run, FIFO contents and state. The first LIT after reset is always preceded by HDR.

Decomposition:
- Package col_enc_pkg holds:
  - tag constants TAG_LIT, TAG_RUN, TAG_HDR
  - state enum (ACCEPT, EMIT_HDR, EMIT_LIT)
  - pack functions for the three word formats, parametrised by width arguments
- One sub-module: enc_sync_fifo (FWFT, WIDTH/DEPTH parameters, level output).

Test Plan:
1. After reset, tik_tok=0x0000_0803, pixel 5 → words 0x8001 (HDR) then 0x001D (LIT), data_ready 1 cycle after each write.
2. 20 zeros then pixel 3, same ts[31:11] window as the prior HDR → 0x4014 then LIT 0x...3, no HDR.
3. 65500 consecutive zeros then flush → 0x7FFF three times, then 0x7FDF (16351); no further words.
4. sink_ready held low 30 cycles under continuous nonzero pixels → fifo_level reaches FIFO_DEPTH, data_accept drops, no loss; on release words drain in order, one per cycle.
5. Two literals straddling tik_tok 0x7FF→0x800 → HDR 0x8001 inserted before the second LIT; run pending at the same time → RUN precedes HDR.
6. rst_n asserted mid EMIT_HDR with 3 words queued → all outputs at reset values immediately; the next pixel yields HDR+LIT only.
